// File: rtl/inv_park_transform.sv
// inv_park_transform: inverse Park rotation (d,q) by theta -> (alpha,beta) using an iterative CORDIC.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with d, q, theta (signed Q1.15 and angle);
//        alpha, beta (saturated signed Q1.15) with out_valid/out_ready.
module inv_park_transform #(
  parameter int ITER  = 16,
  parameter int GUARD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] d,
  input  logic signed [15:0] q,
  input  logic signed [15:0] theta,
  output logic signed [15:0] alpha,
  output logic signed [15:0] beta,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int W  = 18 + GUARD;
  localparam int PW = W + 17;
  localparam logic signed [16:0] INV_K = 17'sd19898;
  localparam logic signed [16:0] ATAN [16] = '{
    17'sd8192, 17'sd4836, 17'sd2555, 17'sd1297, 17'sd651, 17'sd326, 17'sd163, 17'sd81,
    17'sd41,   17'sd20,   17'sd10,   17'sd5,    17'sd3,   17'sd1,   17'sd1,   17'sd0
  };
  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;
  state_t state;
  logic signed [W-1:0] x, y, dx, qx, x0, y0, xn, yn, xs, ys;
  logic signed [16:0] z, th, z0, zn;
  logic signed [PW-1:0] px, py;
  logic [3:0] i;
  logic mul_done, hi, lo, neg;
  function automatic logic signed [15:0] sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + (PW'(1) <<< (14 + GUARD))) >>> (15 + GUARD);
    return r > PW'(32767) ? 16'sd32767 : r < -PW'(32767) ? -16'sd32767 : r[15:0];
  endfunction
  assign dx = {{2{d[15]}}, d, {GUARD{1'b0}}};
  assign qx = {{2{q[15]}}, q, {GUARD{1'b0}}};
  assign th = {theta[15], theta};
  assign hi = theta >= 16'sd16384;
  assign lo = theta < -16'sd16384;
  // quadrant pre-rotation by +/-90 deg keeps the residual angle within the CORDIC convergence range
  assign x0 = hi ? -qx : lo ? qx : dx;
  assign y0 = hi ? dx : lo ? -dx : qx;
  assign z0 = hi ? th - 17'sd16384 : lo ? th + 17'sd16384 : th;
  assign neg = z[16];
  assign xs = x >>> i;
  assign ys = y >>> i;
  assign xn = neg ? x + ys : x - ys;
  assign yn = neg ? y - xs : y + xs;
  assign zn = neg ? z + ATAN[i] : z - ATAN[i];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      alpha     <= '0;
      beta      <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      px        <= '0;
      py        <= '0;
      mul_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x        <= x0;
            y        <= y0;
            z        <= z0;
            i        <= '0;
            in_ready <= 1'b0;
            state    <= ROTATE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROTATE: begin
          x <= xn;
          y <= yn;
          z <= zn;
          i <= i + 4'd1;
          if (i == 4'(ITER - 1)) state <= SCALE;
        end
        // gain correction is split: products registered first, then round/saturate into the outputs
        SCALE: begin
          if (!mul_done) begin
            px       <= x * INV_K;
            py       <= y * INV_K;
            mul_done <= 1'b1;
          end else begin
            alpha     <= sat(px);
            beta      <= sat(py);
            out_valid <= 1'b1;
            mul_done  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_park_transform.sv
// tb_inv_park_transform: directed and swept checks of the inverse Park CORDIC against hand values and a real model.
module tb_inv_park_transform;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [15:0] d = '0, q = '0, theta = '0, alpha, beta;
  int checks = 0, pass_cnt = 0, fail_cnt = 0;
  localparam real PI = 3.14159265358979;
  inv_park_transform dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .q(q), .theta(theta), .alpha(alpha), .beta(beta),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_near(input string tag, input int got, input real expv);
    real diff;
    diff = real'(got) - expv;
    if (diff < 0.0) diff = -diff;
    checks++;
    assert (diff <= 8.0) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0.2f +/-8", tag, got, expv);
    end
  endtask
  function automatic real clip(input real v);
    return v > 32767.0 ? 32767.0 : v < -32767.0 ? -32767.0 : v;
  endfunction
  function automatic real ideal_a(input int dd, input int qq, input int th);
    real t;
    t = real'(th) * PI / 32768.0;
    return clip(real'(dd) * $cos(t) - real'(qq) * $sin(t));
  endfunction
  function automatic real ideal_b(input int dd, input int qq, input int th);
    real t;
    t = real'(th) * PI / 32768.0;
    return clip(real'(dd) * $sin(t) + real'(qq) * $cos(t));
  endfunction
  task automatic xfer(input int dd, input int qq, input int th, output int a, output int b, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    d = 16'(dd);
    q = 16'(qq);
    theta = 16'(th);
    tick();
    in_valid = 1'b0;
    d = 16'($urandom);
    q = 16'($urandom);
    theta = 16'($urandom);
    chk("in_ready_busy", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    a = int'(alpha);
    b = int'(beta);
    chk("latency", lat, 18);
  endtask
  task automatic release_out(input int a, input int b);
    out_ready = 1'b1;
    tick();
    chk("ov_fall", int'(out_valid), 0);
    chk("ir_rise", int'(in_ready), 1);
    chk("alpha_hold", int'(alpha), a);
    chk("beta_hold", int'(beta), b);
    out_ready = 1'b0;
  endtask
  initial begin
    int a, b, lat, seen, dd, qq, th;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_alpha", int'(alpha), 0);
    chk("rst_beta", int'(beta), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", int'(in_ready), 1);
    xfer(16384, 0, 0, a, b, lat);
    chk_near("t0_alpha", a, 16384.0);
    chk_near("t0_beta", b, 0.0);
    release_out(a, b);
    xfer(16384, 0, 16384, a, b, lat);
    chk_near("t90_alpha", a, 0.0);
    chk_near("t90_beta", b, 16384.0);
    release_out(a, b);
    xfer(16384, 0, -32768, a, b, lat);
    chk_near("t180_alpha", a, -16384.0);
    chk_near("t180_beta", b, 0.0);
    release_out(a, b);
    xfer(0, 16384, 8192, a, b, lat);
    chk_near("t45_alpha", a, -11585.0);
    chk_near("t45_beta", b, 11585.0);
    release_out(a, b);
    xfer(-10000, 20000, -12000, a, b, lat);
    chk_near("tneg_alpha", a, ideal_a(-10000, 20000, -12000));
    chk_near("tneg_beta", b, ideal_b(-10000, 20000, -12000));
    release_out(a, b);
    xfer(32767, 32767, 8192, a, b, lat);
    chk_near("sat_alpha", a, 0.0);
    chk("sat_beta", b, 32767);
    in_valid = 1'b1;
    d = 16'sd1234;
    q = -16'sd4321;
    theta = 16'sd999;
    repeat (10) begin
      tick();
      chk("bp_alpha", int'(alpha), a);
      chk("bp_beta", int'(beta), b);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    release_out(a, b);
    seen = 0;
    repeat (25) begin
      tick();
      if (out_valid) seen++;
    end
    chk("no_queued", seen, 0);
    in_valid = 1'b1;
    d = 16'sd20000;
    q = -16'sd5000;
    theta = 16'sd3000;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alpha", int'(alpha), 0);
    chk("mid_rst_beta", int'(beta), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (out_valid) seen++;
    end
    chk("no_stale", seen, 0);
    xfer(-8000, 12000, -20000, a, b, lat);
    chk_near("post_rst_alpha", a, ideal_a(-8000, 12000, -20000));
    chk_near("post_rst_beta", b, ideal_b(-8000, 12000, -20000));
    release_out(a, b);
    for (int k = 0; k < 1000; k++) begin
      dd = int'($urandom_range(0, 23170)) - 11585;
      qq = int'($urandom_range(0, 23170)) - 11585;
      th = int'($urandom_range(0, 65535)) - 32768;
      out_ready = 1'b1;
      xfer(dd, qq, th, a, b, lat);
      chk_near("sweep_alpha", a, ideal_a(dd, qq, th));
      chk_near("sweep_beta", b, ideal_b(dd, qq, th));
      release_out(a, b);
    end
    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end
endmodule
